// File: rtl/mmio_responder.sv
// ---------------------------------------------------------------------------
// mmio_responder
//
// Data-port responder for the single-cycle core. Reads are combinational from
// the current address and state; writes commit on the rising clock edge.
// It backs a word RAM plus a small MMIO window:
//   0xFFFF_0000  TIMER_COUNT  free-running counter, write loads it
//   0xFFFF_0004  TIMER_CMP    compare value
//   0xFFFF_0008  STATUS       {FIFO count[7:4], OVF, EMPTY, FULL, MATCH}
//                             write 1 to bit0 clears MATCH, bit3 clears OVF
//   0xFFFF_000C  TX           write pushes a byte into the TX FIFO, reads 0
// Every other address reads 0 and ignores writes.
//
// Build option: define MMIO_TIMER_EN to build the timer/compare unit. Without
// it, TIMER_COUNT/TIMER_CMP read 0, MATCH reads 0 and irq is tied low.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   WE                  write enable from the processor
//   address_to_mem      byte address, bits [1:0] ignored
//   data_to_mem         write data
//   data_from_mem       read data, same cycle as the address
//   out_valid/out_data  TX FIFO head towards the sink
//   out_ready           sink accepts the head byte
//   irq                 sticky timer MATCH flag
// ---------------------------------------------------------------------------
module mmio_responder #(
    parameter int RAM_WORDS  = 256,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        WE,
    input  logic [31:0] address_to_mem,
    input  logic [31:0] data_to_mem,
    output logic [31:0] data_from_mem,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        irq
);

    // FIFO_DEPTH must be a power of two >= 2 so the pointers wrap naturally.
    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    // Address decode
    logic          ram_sel;
    logic          mmio_sel;
    logic          sel_count;
    logic          sel_cmp;
    logic          sel_status;
    logic          sel_tx;
    logic [AW-1:0] ram_idx;
    logic          clr_match;
    logic          clr_ovf;
    logic          unused_addr_bits;

    assign ram_sel    = (address_to_mem[31:AW+2] == '0);
    assign mmio_sel   = (address_to_mem[31:4] == 28'hFFFF000);
    assign sel_count  = mmio_sel && (address_to_mem[3:2] == 2'd0);
    assign sel_cmp    = mmio_sel && (address_to_mem[3:2] == 2'd1);
    assign sel_status = mmio_sel && (address_to_mem[3:2] == 2'd2);
    assign sel_tx     = mmio_sel && (address_to_mem[3:2] == 2'd3);
    assign ram_idx    = address_to_mem[AW+1:2];
    assign clr_match  = WE && sel_status && data_to_mem[0];
    assign clr_ovf    = WE && sel_status && data_to_mem[3];
    assign unused_addr_bits = ^address_to_mem[1:0];

    // Storage: neither RAM nor FIFO payload is reset
    logic [31:0] ram      [RAM_WORDS];
    logic [7:0]  fifo_mem [FIFO_DEPTH];

    // TX FIFO control
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push_req;
    logic          push;
    logic          pop;

    assign fifo_full  = (cnt_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (cnt_q == '0);
    assign pop        = !fifo_empty && out_ready;
    assign push_req   = WE && sel_tx;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push       = push_req && (!fifo_full || pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (push && !pop)      cnt_d = cnt_q + CW'(1);
        else if (pop && !push) cnt_d = cnt_q - CW'(1);
        // A dropped byte sets OVF even if the same write tries to clear it.
        ovf_d = (push_req && !push) || (ovf_q && !clr_ovf);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (WE && ram_sel) ram[ram_idx] <= data_to_mem;
        if (push)          fifo_mem[wr_ptr_q] <= data_to_mem[7:0];
    end

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_q];

    // Timer / compare unit
    logic [31:0] count_rd;
    logic [31:0] cmp_rd;
    logic        match_rd;

`ifdef MMIO_TIMER_EN
    logic [31:0] count_q, count_d;
    logic [31:0] cmp_q, cmp_d;
    logic        match_q, match_d;

    always_comb begin
        // A software load takes priority over the increment.
        count_d = (WE && sel_count) ? data_to_mem : count_q + 32'd1;
        cmp_d   = (WE && sel_cmp)   ? data_to_mem : cmp_q;
        match_d = (count_q == cmp_q) || (match_q && !clr_match);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            cmp_q   <= '0;
            match_q <= 1'b0;
        end else begin
            count_q <= count_d;
            cmp_q   <= cmp_d;
            match_q <= match_d;
        end
    end

    assign count_rd = count_q;
    assign cmp_rd   = cmp_q;
    assign match_rd = match_q;
`else
    logic unused_timer_bits;
    assign unused_timer_bits = clr_match ^ sel_count ^ sel_cmp;
    assign count_rd = '0;
    assign cmp_rd   = '0;
    assign match_rd = 1'b0;
`endif

    assign irq = match_rd;

    // Read mux
    logic [31:0] status;
    assign status = {24'h0, 4'(cnt_q), ovf_q, fifo_empty, fifo_full, match_rd};

    always_comb begin
        data_from_mem = '0;
        if (ram_sel) begin
            data_from_mem = ram[ram_idx];
        end else if (mmio_sel) begin
            case (address_to_mem[3:2])
                2'd0:    data_from_mem = count_rd;
                2'd1:    data_from_mem = cmp_rd;
                2'd2:    data_from_mem = status;
                default: data_from_mem = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_responder.sv
module tb_mmio_responder;

    localparam int RAM_WORDS  = 256;
    localparam int FIFO_DEPTH = 4;

    localparam logic [31:0] A_COUNT  = 32'hFFFF_0000;
    localparam logic [31:0] A_CMP    = 32'hFFFF_0004;
    localparam logic [31:0] A_STATUS = 32'hFFFF_0008;
    localparam logic [31:0] A_TX     = 32'hFFFF_000C;

`ifdef MMIO_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        WE;
    logic [31:0] address_to_mem;
    logic [31:0] data_to_mem;
    logic [31:0] data_from_mem;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic        irq;

    mmio_responder #(.RAM_WORDS(RAM_WORDS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk),
        .reset(reset),
        .WE(WE),
        .address_to_mem(address_to_mem),
        .data_to_mem(data_to_mem),
        .data_from_mem(data_from_mem),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] m_ram [RAM_WORDS];
    logic [7:0]  m_q [$];
    logic [31:0] m_count;
    logic [31:0] m_cmp;
    logic        m_match;
    logic        m_ovf;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] st;
        if (a < RAM_WORDS * 4) return m_ram[a >> 2];
        if (a[31:4] != 28'hFFFF000) return 32'h0;
        case (a[3:2])
            2'd0: return TIMER ? m_count : 32'h0;
            2'd1: return TIMER ? m_cmp : 32'h0;
            2'd2: begin
                st = 32'(m_q.size()) << 4;
                st[0] = TIMER ? m_match : 1'b0;
                st[1] = (m_q.size() == FIFO_DEPTH);
                st[2] = (m_q.size() == 0);
                st[3] = m_ovf;
                return st;
            end
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_count = 0;
        m_cmp   = 0;
        m_match = 0;
        m_ovf   = 0;
    endtask

    // Next state of the memory map after one clock edge with these inputs.
    task automatic model_step(input logic we, input logic [31:0] a, input logic [31:0] d, input logic rdy);
        bit is_mmio, wr_status, push_req, pop, full, acc;
        is_mmio   = (a[31:4] == 28'hFFFF000);
        wr_status = we && is_mmio && (a[3:2] == 2'd2);
        push_req  = we && is_mmio && (a[3:2] == 2'd3);
        pop       = (m_q.size() > 0) && rdy;
        full      = (m_q.size() == FIFO_DEPTH);
        acc       = push_req && (!full || pop);
        if (TIMER) begin
            m_match = (m_count == m_cmp) || (m_match && !(wr_status && d[0]));
            m_count = (we && is_mmio && a[3:2] == 2'd0) ? d : m_count + 1;
            if (we && is_mmio && a[3:2] == 2'd1) m_cmp = d;
        end
        m_ovf = (push_req && !acc) || (m_ovf && !(wr_status && d[3]));
        if (we && a < RAM_WORDS * 4) m_ram[a >> 2] = d;
        if (pop) void'(m_q.pop_front());
        if (acc) m_q.push_back(d[7:0]);
    endtask

    // One bus cycle: drive after the edge, check mid-cycle, advance the model.
    task automatic cycle(input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic rdy, output logic [31:0] rd);
        WE = we;
        address_to_mem = a;
        data_to_mem = d;
        out_ready = rdy;
        @(negedge clk);
        rd = data_from_mem;
        chk("read", data_from_mem, model_read(a));
        chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
        chk("out_data", 32'(out_data), (m_q.size() != 0) ? 32'(m_q[0]) : 32'h0);
        chk("irq", 32'(irq), TIMER ? 32'(m_match) : 32'h0);
        model_step(we, a, d, rdy);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0, 1:    return 32'($urandom_range(0, RAM_WORDS * 4 - 1));
            2:       return A_COUNT;
            3:       return A_CMP;
            4, 5:    return A_STATUS;
            6, 7:    return A_TX;
            8:       return $urandom;
            default: return 32'hFFFF_0010 + 32'($urandom_range(0, 63));
        endcase
    endfunction

    task automatic random_phase(input int n);
        logic [31:0] a, d, rd;
        for (int i = 0; i < n; i++) begin
            a = rand_addr();
            d = $urandom;
            if (a == A_COUNT && $urandom_range(0, 1) == 1) d = m_cmp - 32'($urandom_range(0, 4));
            cycle(1'($urandom_range(0, 1)), a, d, 1'($urandom_range(0, 1)), rd);
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic [7:0]  exp_bytes [4];

        reset = 1'b1;
        WE = 1'b0;
        address_to_mem = A_STATUS;
        data_to_mem = 32'h0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_status", data_from_mem, 32'h0000_0004);
        address_to_mem = A_COUNT;
        #1;
        chk("rst_count", data_from_mem, 32'h0);
        reset = 1'b0;

        // Fill RAM so every later RAM read has a known value.
        for (int i = 0; i < RAM_WORDS; i++) cycle(1'b1, 32'(i * 4), $urandom, 1'b0, rd);

        cycle(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, rd);
        cycle(1'b0, 32'h0000_0012, 32'h0, 1'b0, rd);
        chk("ram_roundtrip", rd, 32'hDEAD_BEEF);
        cycle(1'b0, 32'h0000_1000, 32'h0, 1'b0, rd);
        chk("ram_unmapped", rd, 32'h0);

`ifdef MMIO_TIMER_EN
        cycle(1'b1, A_CMP, 32'd5, 1'b0, rd);
        cycle(1'b1, A_STATUS, 32'h1, 1'b0, rd);
        cycle(1'b1, A_COUNT, 32'h0, 1'b0, rd);
        for (int k = 0; k < 6; k++) begin
            cycle(1'b0, A_COUNT, 32'h0, 1'b0, rd);
            chk("timer_seq", rd, 32'(k));
        end
        chk("irq_match", 32'(irq), 32'h1);
        cycle(1'b0, A_STATUS, 32'h0, 1'b0, rd);
        chk("status_match", 32'(rd[0]), 32'h1);
        cycle(1'b1, A_STATUS, 32'h1, 1'b0, rd);
        chk("irq_clear", 32'(irq), 32'h0);
        cycle(1'b1, A_COUNT, 32'hFFFF_FFFF, 1'b0, rd);
        cycle(1'b0, A_COUNT, 32'h0, 1'b0, rd);
        chk("timer_max", rd, 32'hFFFF_FFFF);
        cycle(1'b0, A_COUNT, 32'h0, 1'b0, rd);
        chk("timer_wrap", rd, 32'h0);
        cycle(1'b1, A_CMP, 32'h8000_0000, 1'b0, rd);
        cycle(1'b1, A_STATUS, 32'h1, 1'b0, rd);
`else
        cycle(1'b1, A_CMP, 32'd5, 1'b0, rd);
        repeat (10) cycle(1'b0, 32'h0, 32'h0, 1'b0, rd);
        cycle(1'b0, A_COUNT, 32'h0, 1'b0, rd);
        chk("notimer_count", rd, 32'h0);
        cycle(1'b0, A_CMP, 32'h0, 1'b0, rd);
        chk("notimer_cmp", rd, 32'h0);
        chk("notimer_irq", 32'(irq), 32'h0);
`endif

        // FIFO fill and overflow with the sink stalled
        cycle(1'b1, A_STATUS, 32'h8, 1'b0, rd);
        for (int b = 8'h41; b <= 8'h45; b++) cycle(1'b1, A_TX, 32'(b), 1'b0, rd);
        cycle(1'b0, A_STATUS, 32'h0, 1'b0, rd);
        chk("status_full_ovf", rd, 32'h0000_004A);
        chk("head_byte", 32'(out_data), 32'h41);

        // Push while full and popping: accepted, no OVF
        cycle(1'b1, A_STATUS, 32'h8, 1'b0, rd);
        cycle(1'b1, A_TX, 32'h46, 1'b1, rd);
        cycle(1'b0, A_STATUS, 32'h0, 1'b0, rd);
        chk("status_push_pop", rd, 32'h0000_0042);
        exp_bytes = '{8'h42, 8'h43, 8'h44, 8'h46};
        for (int i = 0; i < 4; i++) begin
            chk("drain_byte", 32'(out_data), 32'(exp_bytes[i]));
            cycle(1'b0, A_STATUS, 32'h0, 1'b1, rd);
        end
        chk("drained_valid", 32'(out_valid), 32'h0);

        random_phase(2000);

        // Asynchronous reset in the middle of traffic
        for (int i = 0; i < 16 && m_q.size() != 0; i++) cycle(1'b0, A_STATUS, 32'h0, 1'b1, rd);
        chk("pre_reset_empty", 32'(m_q.size()), 32'h0);
        cycle(1'b1, 32'h0000_0020, 32'h1234_5678, 1'b0, rd);
        for (int b = 1; b <= 3; b++) cycle(1'b1, A_TX, 32'(b), 1'b0, rd);
        if (TIMER) begin
            cycle(1'b1, A_CMP, m_count + 1, 1'b0, rd);
            cycle(1'b0, A_STATUS, 32'h0, 1'b0, rd);
        end
        WE = 1'b0;
        address_to_mem = A_COUNT;
        reset = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'h0);
        chk("arst_out_data", 32'(out_data), 32'h0);
        chk("arst_irq", 32'(irq), 32'h0);
        chk("arst_count", data_from_mem, 32'h0);
        model_reset();
        #1;
        reset = 1'b0;
        cycle(1'b0, 32'h0000_0020, 32'h0, 1'b0, rd);
        chk("ram_retained", rd, 32'h1234_5678);
        cycle(1'b0, A_STATUS, 32'h0, 1'b0, rd);

        random_phase(500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
